// File: rtl/facto_job_sched.sv
// rtl/facto_job_sched.sv - queued factorial job sequencer driving one FactoCore slave port (optional FACTO_TIMEOUT_EN)
module facto_job_sched #(
    parameter int JOB_DEPTH      = 4,
    parameter int RES_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [63:0] job_operand,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_operand,
    output logic [63:0] res_hi,
    output logic [63:0] res_lo,
    output logic        res_err,
    output logic        m_sel,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    input  logic        core_int,
    output logic        busy,
    output logic [15:0] jobs_done
);
    localparam int JAW   = $clog2(JOB_DEPTH);
    localparam int RAW   = $clog2(RES_DEPTH);
    localparam int RES_W = 193;

    localparam logic [15:0] A_START = 16'h7000;
    localparam logic [15:0] A_CLEAR = 16'h7008;
    localparam logic [15:0] A_INTEN = 16'h7018;
    localparam logic [15:0] A_OPER  = 16'h7020;
    localparam logic [15:0] A_RESH  = 16'h7028;
    localparam logic [15:0] A_RESL  = 16'h7030;

    typedef enum logic [3:0] {
        IDLE, CLR1, CLR0, OPR, INTEN, START, WAIT_INT, RDH, RDL, PUSH
    } state_t;

    state_t state, next_state;

    logic [63:0]      job_mem [JOB_DEPTH];
    logic [JAW:0]     job_wr_ptr, job_rd_ptr;
    logic             job_empty, job_full, job_push, job_pop;

    logic [RES_W-1:0] res_mem [RES_DEPTH];
    logic [RAW:0]     res_wr_ptr, res_rd_ptr;
    logic             res_empty, res_full, res_push, res_pop;
    logic [RES_W-1:0] res_head;

    logic [63:0]      op_reg, hi_reg, lo_reg;
    logic             err_reg;
    logic             timeout_hit;

    logic             nxt_sel, nxt_wr;
    logic [15:0]      nxt_addr;
    logic [63:0]      nxt_wdata;

    // Job FIFO flags: the extra pointer MSB separates full from empty
    assign job_empty = (job_wr_ptr == job_rd_ptr);
    assign job_full  = (job_wr_ptr[JAW] != job_rd_ptr[JAW]) &&
                       (job_wr_ptr[JAW-1:0] == job_rd_ptr[JAW-1:0]);
    assign job_ready = !job_full;
    assign job_push  = job_valid && !job_full;
    assign job_pop   = (state == IDLE) && !job_empty;

    // Result FIFO flags; a push on full is accepted only when the head leaves in the same cycle
    assign res_empty = (res_wr_ptr == res_rd_ptr);
    assign res_full  = (res_wr_ptr[RAW] != res_rd_ptr[RAW]) &&
                       (res_wr_ptr[RAW-1:0] == res_rd_ptr[RAW-1:0]);
    assign res_pop   = res_ready && !res_empty;
    assign res_push  = (state == PUSH) && (!res_full || res_pop);

    assign res_valid   = !res_empty;
    assign res_head    = res_mem[res_rd_ptr[RAW-1:0]];
    assign res_operand = res_head[192:129];
    assign res_hi      = res_head[128:65];
    assign res_lo      = res_head[64:1];
    assign res_err     = res_head[0];

    assign busy = (state != IDLE);

`ifdef FACTO_TIMEOUT_EN
    logic [31:0] wait_cnt;

    // Wait counter: restarts on entry to WAIT_INT, advances each cycle spent waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (state == START)
            wait_cnt <= '0;
        else if (state == WAIT_INT)
            wait_cnt <= wait_cnt + 32'd1;
    end

    assign timeout_hit = (state == WAIT_INT) && !core_int &&
                         (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Job FIFO storage write
    always_ff @(posedge clk) begin
        if (job_push)
            job_mem[job_wr_ptr[JAW-1:0]] <= job_operand;
    end

    // Job FIFO pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job_wr_ptr <= '0;
            job_rd_ptr <= '0;
        end else begin
            if (job_push)
                job_wr_ptr <= job_wr_ptr + 1'b1;
            if (job_pop)
                job_rd_ptr <= job_rd_ptr + 1'b1;
        end
    end

    // Result FIFO storage write
    always_ff @(posedge clk) begin
        if (res_push)
            res_mem[res_wr_ptr[RAW-1:0]] <= {op_reg, hi_reg, lo_reg, err_reg};
    end

    // Result FIFO pointers and completed-job counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            jobs_done  <= '0;
        end else begin
            if (res_push) begin
                res_wr_ptr <= res_wr_ptr + 1'b1;
                jobs_done  <= jobs_done + 16'd1;
            end
            if (res_pop)
                res_rd_ptr <= res_rd_ptr + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next state, and the bus cycle belonging to the state being entered
    always_comb begin
        next_state = state;
        nxt_sel    = 1'b0;
        nxt_wr     = 1'b0;
        nxt_addr   = 16'h0000;
        nxt_wdata  = 64'd0;
        case (state)
            IDLE:     if (!job_empty) next_state = CLR1;
            CLR1:     next_state = CLR0;
            CLR0:     next_state = OPR;
            OPR:      next_state = INTEN;
            INTEN:    next_state = START;
            START:    next_state = WAIT_INT;
            WAIT_INT: begin
                if (core_int)
                    next_state = RDH;
                else if (timeout_hit)
                    next_state = PUSH;
            end
            RDH:      next_state = RDL;
            RDL:      next_state = PUSH;
            PUSH:     if (res_push) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        case (next_state)
            CLR1:  begin nxt_sel = 1'b1; nxt_wr = 1'b1; nxt_addr = A_CLEAR; nxt_wdata = 64'd1;  end
            CLR0:  begin nxt_sel = 1'b1; nxt_wr = 1'b1; nxt_addr = A_CLEAR; nxt_wdata = 64'd0;  end
            OPR:   begin nxt_sel = 1'b1; nxt_wr = 1'b1; nxt_addr = A_OPER;  nxt_wdata = op_reg; end
            INTEN: begin nxt_sel = 1'b1; nxt_wr = 1'b1; nxt_addr = A_INTEN; nxt_wdata = 64'd1;  end
            START: begin nxt_sel = 1'b1; nxt_wr = 1'b1; nxt_addr = A_START; nxt_wdata = 64'd1;  end
            RDH:   begin nxt_sel = 1'b1; nxt_addr = A_RESH; end
            RDL:   begin nxt_sel = 1'b1; nxt_addr = A_RESL; end
            default: ;
        endcase
    end

    // Registered bus outputs so every transfer lines up with its state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_sel   <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= 16'h0000;
            m_wdata <= 64'd0;
        end else begin
            m_sel   <= nxt_sel;
            m_wr    <= nxt_wr;
            m_addr  <= nxt_addr;
            m_wdata <= nxt_wdata;
        end
    end

    // Job datapath: operand load, read-data capture at the end of each read cycle, abort values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg  <= 64'd0;
            hi_reg  <= 64'd0;
            lo_reg  <= 64'd0;
            err_reg <= 1'b0;
        end else begin
            if (job_pop) begin
                op_reg  <= job_mem[job_rd_ptr[JAW-1:0]];
                hi_reg  <= 64'd0;
                lo_reg  <= 64'd0;
                err_reg <= 1'b0;
            end
            if (state == RDH)
                hi_reg <= m_rdata;
            if (state == RDL)
                lo_reg <= m_rdata;
            if (timeout_hit) begin
                hi_reg  <= 64'd0;
                lo_reg  <= 64'd0;
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_facto_job_sched.sv
// tb/tb_facto_job_sched.sv - randomized scoreboard bench for facto_job_sched with a behavioural FactoCore
module tb_facto_job_sched;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        job_valid;
    logic        job_ready;
    logic [63:0] job_operand;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_operand, res_hi, res_lo;
    logic        res_err;
    logic        m_sel, m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        core_int = 1'b0;
    logic        busy;
    logic [15:0] jobs_done;

    always #5 clk = ~clk;

    facto_job_sched #(.JOB_DEPTH(4), .RES_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_operand(job_operand),
        .res_valid(res_valid), .res_ready(res_ready), .res_operand(res_operand),
        .res_hi(res_hi), .res_lo(res_lo), .res_err(res_err),
        .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .core_int(core_int), .busy(busy), .jobs_done(jobs_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r = 128'd1;
        for (logic [63:0] i = 64'd2; i <= n; i++)
            r = r * 128'(i);
        return r;
    endfunction

    // Behavioural FactoCore: result ready a few cycles after start, interrupt held until cleared
    logic [63:0]  core_op = 64'd0;
    logic [127:0] core_res = 128'd0;
    int           core_cnt = 0;
    logic         core_run = 1'b0;
    int           core_delay = 2;
    logic         core_silent = 1'b0;

    assign m_rdata = (m_addr == 16'h7028) ? core_res[127:64] :
                     (m_addr == 16'h7030) ? core_res[63:0] : 64'd0;

    always @(posedge clk) begin
        if (m_sel && m_wr) begin
            if (m_addr == 16'h7008 && m_wdata[0]) begin
                core_int <= 1'b0;
                core_run <= 1'b0;
            end else if (m_addr == 16'h7020) begin
                core_op <= m_wdata;
            end else if (m_addr == 16'h7000) begin
                core_run <= 1'b1;
                core_cnt <= (core_op == 64'd72) ? 60 : core_delay;
                core_res <= fact(core_op);
            end
        end else if (core_run) begin
            if (core_cnt == 0) begin
                core_run <= 1'b0;
                if (!core_silent)
                    core_int <= 1'b1;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Transaction-level expectations: bus transfers and results, in job order
    typedef struct { logic wr; logic [15:0] addr; logic [63:0] wdata; } bus_op_t;
    typedef struct { logic [63:0] op; logic [63:0] hi; logic [63:0] lo; logic err; } res_t;

    bus_op_t exp_bus[$];
    res_t    exp_res[$];
    int      model_done = 0;
    logic    saw_full = 1'b0;

    function automatic bus_op_t mk_op(input logic wr, input logic [15:0] a, input logic [63:0] d);
        bus_op_t o;
        o.wr = wr; o.addr = a; o.wdata = d;
        return o;
    endfunction

    task automatic model_accept(input logic [63:0] n);
        res_t r;
        logic [127:0] f;
        exp_bus.push_back(mk_op(1'b1, 16'h7008, 64'd1));
        exp_bus.push_back(mk_op(1'b1, 16'h7008, 64'd0));
        exp_bus.push_back(mk_op(1'b1, 16'h7020, n));
        exp_bus.push_back(mk_op(1'b1, 16'h7018, 64'd1));
        exp_bus.push_back(mk_op(1'b1, 16'h7000, 64'd1));
        r.op = n;
        if (core_silent) begin
            r.hi = 64'd0; r.lo = 64'd0; r.err = 1'b1;
        end else begin
            exp_bus.push_back(mk_op(1'b0, 16'h7028, 64'd0));
            exp_bus.push_back(mk_op(1'b0, 16'h7030, 64'd0));
            f = fact(n);
            r.hi = f[127:64]; r.lo = f[63:0]; r.err = 1'b0;
        end
        exp_res.push_back(r);
    endtask

    logic        prev_hold = 1'b0;
    logic [63:0] prev_op, prev_hi, prev_lo;
    logic        prev_err;

    // Per-cycle compare against the scoreboard
    always @(negedge clk) begin
        bus_op_t o;
        res_t    r;
        if (reset_n) begin
            if (job_valid && job_ready)
                model_accept(job_operand);
            if (job_valid && !job_ready && busy)
                saw_full = 1'b1;
            if (m_sel) begin
                if (exp_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got transfer addr 0x%0h expected none", m_addr);
                end else begin
                    o = exp_bus.pop_front();
                    check("bus_wr", 64'(m_wr), 64'(o.wr));
                    check("bus_addr", 64'(m_addr), 64'(o.addr));
                    if (o.wr)
                        check("bus_wdata", m_wdata, o.wdata);
                end
            end
            if (prev_hold) begin
                check("hold_valid", 64'(res_valid), 64'd1);
                check("hold_operand", res_operand, prev_op);
                check("hold_hi", res_hi, prev_hi);
                check("hold_lo", res_lo, prev_lo);
                check("hold_err", 64'(res_err), 64'(prev_err));
            end
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL res_unexpected: got operand 0x%0h expected none", res_operand);
                end else begin
                    r = exp_res.pop_front();
                    check("res_operand", res_operand, r.op);
                    check("res_hi", res_hi, r.hi);
                    check("res_lo", res_lo, r.lo);
                    check("res_err", 64'(res_err), 64'(r.err));
                    model_done++;
                end
            end
            prev_hold = res_valid && !res_ready;
            prev_op   = res_operand;
            prev_hi   = res_hi;
            prev_lo   = res_lo;
            prev_err  = res_err;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic push_job(input logic [63:0] n);
        int k = 0;
        job_operand = n;
        job_valid   = 1'b1;
        while (!job_ready && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!job_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: got job_ready 0 expected 1");
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((busy || res_valid || exp_res.size() != 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(k < 5000), 64'd1);
    endtask

    task automatic wait_res_valid(input string name);
        int k = 0;
        while (!res_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(res_valid), 64'd1);
    endtask

    initial begin
        int k;
        int base;
        int sent;
        int cnt;
        logic acc;

        reset_n = 1'b0; job_valid = 1'b0; job_operand = 64'd0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_m_sel", 64'(m_sel), 64'd0);
        check("rst_m_wr", 64'(m_wr), 64'd0);
        check("rst_m_addr", 64'(m_addr), 64'd0);
        check("rst_m_wdata", m_wdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_jobs_done", 64'(jobs_done), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_job_ready", 64'(job_ready), 64'd1);

        // T1: single job, result held then read
        @(posedge clk); #1;
        push_job(64'd5);
        wait_res_valid("t1_res_valid");
        check("t1_lo_literal", res_lo, 64'd120);
        check("t1_hi_literal", res_hi, 64'd0);
        check("t1_operand_literal", res_operand, 64'd5);
        check("t1_jobs_done", 64'(jobs_done), 64'd1);
        @(posedge clk); #1 res_ready = 1'b1;
        wait_idle("t1_drain");

        // T2: burst; job FIFO fills while the first job runs
        saw_full = 1'b0;
        push_job(64'd0); push_job(64'd1); push_job(64'd2);
        push_job(64'd5); push_job(64'd3); push_job(64'd4);
        wait_idle("t2_drain");
        check("t2_job_ready_dropped", 64'(saw_full), 64'd1);
        check("t2_jobs_done", 64'(jobs_done), 64'(model_done));

        // T3: result backpressure parks the sequencer in PUSH
        base = model_done;
        @(posedge clk); #1 res_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_job(64'd3);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("t3_jobs_done_parked", 64'(jobs_done), 64'(base + 4));
        check("t3_res_valid", 64'(res_valid), 64'd1);
        check("t3_lo_literal", res_lo, 64'd6);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_m_sel", 64'(m_sel), 64'd0);
        @(posedge clk); #1 res_ready = 1'b1;
        wait_idle("t3_drain");
        check("t3_jobs_done", 64'(jobs_done), 64'(base + 6));

        // T4: reset while waiting for the core interrupt
        push_job(64'd72);
        k = 0;
        while (!(m_sel && m_addr == 16'h7000) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t4_start_seen", 64'(k < 200), 64'd1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t4_m_sel", 64'(m_sel), 64'd0);
        check("t4_m_wr", 64'(m_wr), 64'd0);
        check("t4_m_addr", 64'(m_addr), 64'd0);
        check("t4_m_wdata", m_wdata, 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_jobs_done", 64'(jobs_done), 64'd0);
        check("t4_res_valid", 64'(res_valid), 64'd0);
        check("t4_job_ready", 64'(job_ready), 64'd1);
        exp_bus.delete();
        exp_res.delete();
        model_done = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        push_job(64'd1);
        wait_idle("t4_drain");
        check("t4_jobs_done_after", 64'(jobs_done), 64'd1);

`ifdef FACTO_TIMEOUT_EN
        // T5: silent core; the job is aborted after the wait budget
        core_silent = 1'b1;
        push_job(64'd9);
        k = 0;
        while (!(m_sel && m_addr == 16'h7000) && k < 200) begin
            @(negedge clk);
            k++;
        end
        cnt = 0;
        while (!res_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("t5_abort_latency", 64'(cnt), 64'd18);
        check("t5_err_literal", 64'(res_err), 64'd1);
        check("t5_lo_literal", res_lo, 64'd0);
        wait_idle("t5_drain");
        core_silent = 1'b0;
        push_job(64'd4);
        wait_idle("t5_next_drain");
`endif

        // T6: pop and push on a full result FIFO in the same cycle
        base = model_done;
        @(posedge clk); #1 res_ready = 1'b0;
        push_job(64'd4); push_job(64'd6); push_job(64'd7); push_job(64'd8); push_job(64'd9);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("t6_jobs_done_full", 64'(jobs_done), 64'(base + 4));
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        check("t6_jobs_done_swap", 64'(jobs_done), 64'(base + 5));
        check("t6_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 res_ready = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (res_valid && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("t6_occupancy", 64'(cnt), 64'd4);

        // Randomized phase: random operands, core delays and result backpressure
        sent = 0; k = 0;
        job_valid = 1'b0;
        @(posedge clk); #1;
        while ((sent < 20 || exp_res.size() != 0 || busy) && k < 20000) begin
            res_ready  = ($urandom_range(0, 3) != 0);
            core_delay = $urandom_range(0, 8);
            if (!job_valid && sent < 20 && $urandom_range(0, 1) == 1) begin
                job_valid   = 1'b1;
                job_operand = 64'($urandom_range(0, 30));
            end
            acc = job_valid && job_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                job_valid = 1'b0;
            end
            k++;
        end
        check("rand_finished", 64'(k < 20000), 64'd1);
        res_ready = 1'b1;
        wait_idle("rand_drain");
        check("rand_jobs_done", 64'(jobs_done), 64'(model_done));
        check("bus_queue_empty", 64'(exp_bus.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
